// File: rtl/pixie_line_shifter_if.sv
// Pixel-side bus of the line shifter: display timing and DMA inputs, video and status outputs.
// The master drives timing/DMA; the slave (the shifter) returns video and sticky flags.
interface pixie_line_shifter_if;
    logic       pix_ce;
    logic       line_start;
    logic       dma_valid;
    logic [7:0] dma_data;
    logic       video;
    logic       active;
    logic       underrun;
    logic       overflow;

    modport master (
        output pix_ce, line_start, dma_valid, dma_data,
        input  video, active, underrun, overflow
    );

    modport slave (
        input  pix_ce, line_start, dma_valid, dma_data,
        output video, active, underrun, overflow
    );
endinterface

// File: rtl/pixie_line_shifter.sv
// Two-bank scanline buffer: DMA fills one bank while the other is serialised
// MSB-first into 8*BYTES_PER_LINE pixels, starting H_START pix_ce ticks after line_start.
module pixie_line_shifter #(
    parameter int BYTES_PER_LINE = 8,
    parameter int H_START        = 14
) (
    input  logic clk,
    input  logic reset,
    pixie_line_shifter_if.slave bus
);
    localparam int NPIX      = 8 * BYTES_PER_LINE;
    localparam int PX_W      = $clog2(NPIX);
    localparam int BI_W      = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam int WI_W      = $clog2(BYTES_PER_LINE + 1);
    localparam int LD_W      = (H_START > 1) ? $clog2(H_START) : 1;
    localparam int LEAD_INIT = (H_START > 0) ? H_START - 1 : 0;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT} state_t;

    logic       pix_ce, line_start, dma_valid;
    logic [7:0] dma_data;

    assign pix_ce     = bus.pix_ce;
    assign line_start = bus.line_start;
    assign dma_valid  = bus.dma_valid;
    assign dma_data   = bus.dma_data;

    // Emits the pixel at the MSB (blanked when the line is invalid) and the byte shifted left.
    function automatic logic [8:0] shift_step(input logic [7:0] src, input logic valid);
        return {src[7] & valid, src[6:0], 1'b0};
    endfunction

    logic [7:0]      line_mem [2][BYTES_PER_LINE];
    logic [WI_W-1:0] wr_idx;
    logic            wr_bank;
    logic            show_valid;
    logic            underrun_q, overflow_q;

    logic            accept, wr_full, swap, wr_bank_nxt;
    logic            rd_bank, rd_valid;
    logic [BI_W-1:0] wr_addr;

    assign accept      = line_start & pix_ce;
    assign wr_full     = (wr_idx == WI_W'(BYTES_PER_LINE));
    assign swap        = accept & wr_full;
    assign wr_bank_nxt = swap ? ~wr_bank : wr_bank;
    assign wr_addr     = accept ? '0 : wr_idx[BI_W-1:0];
    // The show bank is always the one not being written; on a swapping edge it is the bank just filled.
    assign rd_bank     = swap ? wr_bank : ~wr_bank;
    assign rd_valid    = accept ? wr_full : show_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            show_valid <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            wr_bank    <= wr_bank_nxt;
            show_valid <= wr_full;
            wr_idx     <= dma_valid ? WI_W'(1) : '0;
            if (!wr_full)
                underrun_q <= 1'b1;
        end else if (dma_valid) begin
            if (wr_full)
                overflow_q <= 1'b1;
            else
                wr_idx <= wr_idx + WI_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (dma_valid && (accept || !wr_full))
            line_mem[wr_bank_nxt][wr_addr] <= dma_data;
    end

    state_t          state_q, state_nxt;
    logic [LD_W-1:0] lead_cnt, lead_nxt;
    logic [PX_W-1:0] px_cnt, px_nxt, nxt_px;
    logic [7:0]      shifter_p0, shifter_p1;
    logic            video_p0, video_p1;
    logic            active_p0, active_p1;
    logic [7:0]      byte0, byte_nxt;
    logic [8:0]      step0, step_nxt, step_sh;

    assign nxt_px   = px_cnt + PX_W'(1);
    assign byte0    = line_mem[rd_bank][0];
    assign byte_nxt = line_mem[rd_bank][nxt_px[PX_W-1:3]];
    assign step0    = shift_step(byte0, rd_valid);
    assign step_nxt = shift_step(byte_nxt, rd_valid);
    assign step_sh  = shift_step(shifter_p1, rd_valid);

    always_comb begin
        state_nxt  = state_q;
        lead_nxt   = lead_cnt;
        px_nxt     = px_cnt;
        shifter_p0 = shifter_p1;
        video_p0   = video_p1;
        active_p0  = active_p1;
        if (pix_ce) begin
            if (line_start) begin
                if (H_START == 0) begin
                    state_nxt  = SHIFT;
                    px_nxt     = '0;
                    video_p0   = step0[8];
                    shifter_p0 = step0[7:0];
                    active_p0  = 1'b1;
                end else begin
                    state_nxt = LEAD;
                    lead_nxt  = LD_W'(LEAD_INIT);
                    video_p0  = 1'b0;
                    active_p0 = 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        video_p0  = 1'b0;
                        active_p0 = 1'b0;
                    end
                    LEAD: begin
                        // Pixel 0 is emitted on the same tick the lead-in expires.
                        if (lead_cnt == '0) begin
                            state_nxt  = SHIFT;
                            px_nxt     = '0;
                            video_p0   = step0[8];
                            shifter_p0 = step0[7:0];
                            active_p0  = 1'b1;
                        end else begin
                            lead_nxt = lead_cnt - LD_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (px_cnt == PX_W'(NPIX - 1)) begin
                            state_nxt = IDLE;
                            video_p0  = 1'b0;
                            active_p0 = 1'b0;
                        end else begin
                            px_nxt    = nxt_px;
                            active_p0 = 1'b1;
                            if (nxt_px[2:0] == 3'd0) begin
                                video_p0   = step_nxt[8];
                                shifter_p0 = step_nxt[7:0];
                            end else begin
                                video_p0   = step_sh[8];
                                shifter_p0 = step_sh[7:0];
                            end
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // display stage: registered FSM state, pixel output and active flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lead_cnt  <= '0;
            px_cnt    <= '0;
            video_p1  <= 1'b0;
            active_p1 <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            lead_cnt  <= lead_nxt;
            px_cnt    <= px_nxt;
            video_p1  <= video_p0;
            active_p1 <= active_p0;
        end
    end

    always_ff @(posedge clk) begin
        shifter_p1 <= shifter_p0;
    end

    assign bus.video    = video_p1;
    assign bus.active   = active_p1;
    assign bus.underrun = underrun_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pixie_line_shifter.sv
// Directed bench for pixie_line_shifter with BYTES_PER_LINE=8, H_START=14.
// Tick 1 is the line_start edge; pixel k appears after tick 15+k.
module tb_pixie_line_shifter;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic act_t [0:99];
    logic vid_t [0:99];

    pixie_line_shifter_if bus();

    pixie_line_shifter #(.BYTES_PER_LINE(8), .H_START(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.dma_valid = 1'b1;
        bus.dma_data  = b;
        cyc();
        bus.dma_valid = 1'b0;
    endtask

    task automatic pulse_line();
        bus.line_start = 1'b1;
        cyc();
        bus.line_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Captures active/video after ticks 2..90 following a line_start tick.
    task automatic run_line();
        for (int t = 2; t <= 90; t++) begin
            cyc();
            act_t[t] = bus.active;
            vid_t[t] = bus.video;
        end
    endtask

    function automatic int count_act(input int lo, input int hi);
        int n = 0;
        for (int t = lo; t <= hi; t++) n += int'(act_t[t]);
        return n;
    endfunction

    function automatic int count_vid(input int lo, input int hi);
        int n = 0;
        for (int t = lo; t <= hi; t++) n += int'(vid_t[t]);
        return n;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.video, bus.active, bus.underrun, bus.overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {bus.video, bus.active, bus.underrun, bus.overflow});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic_line();
        do_reset();
        send_byte(8'h80);
        for (int i = 0; i < 6; i++) send_byte(8'h00);
        send_byte(8'h01);
        pulse_line();
        run_line();
        checks++;
        if (act_t[14] !== 1'b0) begin
            failures++; $display("FAIL basic_active_t14 got=%b exp=0", act_t[14]);
        end
        checks++;
        if ({act_t[15], vid_t[15]} !== 2'b11) begin
            failures++; $display("FAIL basic_pixel0 got=%b exp=11", {act_t[15], vid_t[15]});
        end
        checks++;
        if (count_vid(16, 77) != 0) begin
            failures++; $display("FAIL basic_pixels_1_62 got=%0d exp=0", count_vid(16, 77));
        end
        checks++;
        if (vid_t[78] !== 1'b1) begin
            failures++; $display("FAIL basic_pixel63 got=%b exp=1", vid_t[78]);
        end
        checks++;
        if (count_act(2, 90) != 64 || act_t[79] !== 1'b0) begin
            failures++; $display("FAIL basic_active_len got=%0d exp=64", count_act(2, 90));
        end
        checks++;
        if ({bus.underrun, bus.overflow} !== 2'b00) begin
            failures++; $display("FAIL basic_flags got=%b exp=00", {bus.underrun, bus.overflow});
        end
    endtask

    task automatic test_underrun();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'hFF);
        pulse_line();
        checks++;
        if (bus.underrun !== 1'b1) begin
            failures++; $display("FAIL underrun_flag got=%b exp=1", bus.underrun);
        end
        run_line();
        checks++;
        if (count_act(2, 90) != 64) begin
            failures++; $display("FAIL underrun_active_len got=%0d exp=64", count_act(2, 90));
        end
        checks++;
        if (count_vid(2, 90) != 0) begin
            failures++; $display("FAIL underrun_blank got=%0d exp=0", count_vid(2, 90));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'h01);
        for (int i = 0; i < 7; i++) send_byte(8'h00);
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++; $display("FAIL overflow_early got=%b exp=0", bus.overflow);
        end
        send_byte(8'hFF);
        checks++;
        if (bus.overflow !== 1'b1) begin
            failures++; $display("FAIL overflow_flag got=%b exp=1", bus.overflow);
        end
        pulse_line();
        run_line();
        checks++;
        if (vid_t[22] !== 1'b1 || count_vid(2, 90) != 1) begin
            failures++; $display("FAIL overflow_line got=%0d ones exp=1 at pixel7", count_vid(2, 90));
        end
        checks++;
        if (bus.underrun !== 1'b0) begin
            failures++; $display("FAIL overflow_underrun got=%b exp=0", bus.underrun);
        end
    endtask

    task automatic test_coincident_dma();
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        bus.line_start = 1'b1;
        bus.dma_valid  = 1'b1;
        bus.dma_data   = 8'hFF;
        cyc();
        bus.line_start = 1'b0;
        bus.dma_valid  = 1'b0;
        bus.pix_ce     = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'h00);
        bus.pix_ce = 1'b1;
        run_line();
        checks++;
        if (count_vid(2, 90) != 0 || count_act(2, 90) != 64) begin
            failures++; $display("FAIL coinc_first_line got=%0d ones exp=0", count_vid(2, 90));
        end
        pulse_line();
        run_line();
        checks++;
        if (count_vid(15, 22) != 8 || count_vid(2, 90) != 8) begin
            failures++; $display("FAIL coinc_byte0 got=%0d ones exp=8", count_vid(2, 90));
        end
        checks++;
        if ({bus.underrun, bus.overflow} !== 2'b00) begin
            failures++; $display("FAIL coinc_flags got=%b exp=00", {bus.underrun, bus.overflow});
        end
    endtask

    task automatic test_abort_freeze();
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'hAA);
        pulse_line();
        for (int t = 2; t <= 25; t++) cyc();
        checks++;
        if ({bus.active, bus.video} !== 2'b11) begin
            failures++; $display("FAIL abort_pixel10 got=%b exp=11", {bus.active, bus.video});
        end
        bus.pix_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({bus.active, bus.video} !== 2'b11) begin
                failures++; $display("FAIL freeze_hold clk=%0d got=%b exp=11", i, {bus.active, bus.video});
            end
        end
        bus.pix_ce    = 1'b1;
        bus.dma_valid = 1'b1;
        bus.dma_data  = 8'h80;
        for (int t = 26; t <= 33; t++) begin
            cyc();
            if (t == 26) begin
                checks++;
                if (bus.video !== 1'b0) begin
                    failures++; $display("FAIL freeze_resume_pixel11 got=%b exp=0", bus.video);
                end
            end
        end
        bus.dma_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (bus.video !== 1'b1) begin
            failures++; $display("FAIL abort_pixel20 got=%b exp=1", bus.video);
        end
        pulse_line();
        checks++;
        if ({bus.active, bus.video} !== 2'b00) begin
            failures++; $display("FAIL abort_drop got=%b exp=00", {bus.active, bus.video});
        end
        run_line();
        checks++;
        if (act_t[14] !== 1'b0 || {act_t[15], vid_t[15]} !== 2'b11 || vid_t[16] !== 1'b0) begin
            failures++; $display("FAIL abort_new_line got=%b exp=0110",
                                 {act_t[14], act_t[15], vid_t[15], vid_t[16]});
        end
        checks++;
        if (bus.underrun !== 1'b0) begin
            failures++; $display("FAIL abort_underrun got=%b exp=0", bus.underrun);
        end
    endtask

    task automatic test_async_reset_mid_shift();
        do_reset();
        pulse_line();
        for (int i = 0; i < 9; i++) send_byte(8'hFF);
        pulse_line();
        for (int t = 2; t <= 20; t++) cyc();
        checks++;
        if ({bus.video, bus.active, bus.underrun, bus.overflow} !== 4'b1111) begin
            failures++; $display("FAIL midshift_pre got=%b exp=1111",
                                 {bus.video, bus.active, bus.underrun, bus.overflow});
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.video, bus.active, bus.underrun, bus.overflow} !== 4'b0000) begin
            failures++; $display("FAIL midshift_async_reset got=%b exp=0000",
                                 {bus.video, bus.active, bus.underrun, bus.overflow});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        reset          = 1'b1;
        bus.pix_ce     = 1'b1;
        bus.line_start = 1'b0;
        bus.dma_valid  = 1'b0;
        bus.dma_data   = 8'h00;
        test_reset();
        test_basic_line();
        test_underrun();
        test_overflow();
        test_coincident_dma();
        test_abort_freeze();
        test_async_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
